// File: rtl/sn_pkt_write_sequencer_if.sv
// Bus bundle between the packet-tap stream, the sequencer and the packet memory.
// slave  : sequencer view (consumes the stream, drives the write bus)
// master : environment view (drives the stream and buf_rdy, observes writes)
interface sn_pkt_write_sequencer_if #(
    parameter int IN_WIDTH      = 32,
    parameter int IN_ADDR_WIDTH = 10,
    parameter int INC_WIDTH     = $clog2(IN_WIDTH / 8) + 1
);
    logic                     buf_rdy;
    logic [IN_WIDTH-1:0]      s_tdata;
    logic [INC_WIDTH-1:0]     s_tbytes;
    logic                     s_tvalid;
    logic                     s_tlast;
    logic                     s_tready;
    logic [IN_ADDR_WIDTH-1:0] in_addr;
    logic [IN_WIDTH-1:0]      in_wr_data;
    logic                     in_wr_en;
    logic [INC_WIDTH-1:0]     in_byte_inc;
    logic                     in_done;
    logic                     truncated;

    modport slave (
        input  buf_rdy, s_tdata, s_tbytes, s_tvalid, s_tlast,
        output s_tready, in_addr, in_wr_data, in_wr_en, in_byte_inc, in_done, truncated
    );

    modport master (
        output buf_rdy, s_tdata, s_tbytes, s_tvalid, s_tlast,
        input  s_tready, in_addr, in_wr_data, in_wr_en, in_byte_inc, in_done, truncated
    );
endinterface

// File: rtl/sn_pkt_write_sequencer.sv
// Packet write sequencer: turns a valid/ready/last stream into addressed buffer writes,
// truncates packets longer than the buffer and keeps saturating statistics.
// Optional feature macro: SN_SEQ_DROP_WHEN_BUSY_EN -- when defined, packets arriving
// while no buffer is free are consumed and counted in drop_cnt instead of back-pressuring.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a free buffer (optionally dropping busy packets)
// ST_WRITE | accepting beats and writing them at addr, addr+1, ...
// ST_DROP  | discarding the rest of a packet until its last beat
// ST_FLUSH | one dead cycle so memory can withdraw buf_rdy
module sn_pkt_write_sequencer #(
    parameter int IN_WIDTH      = 32,
    parameter int IN_ADDR_WIDTH = 10,
    parameter int INC_WIDTH     = $clog2(IN_WIDTH / 8) + 1,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    sn_pkt_write_sequencer_if.slave       bus,
    output logic [CNT_WIDTH-1:0]          pkt_cnt,
    output logic [CNT_WIDTH-1:0]          trunc_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DROP,
        ST_FLUSH
    } state_t;

    localparam logic [INC_WIDTH-1:0]     FULL_INC  = INC_WIDTH'(IN_WIDTH / 8);
    localparam logic [IN_ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                   state;
    logic [IN_ADDR_WIDTH-1:0] addr;
    logic                     rdy_q;
    logic                     drop_to_idle;

    logic                     tready;
    logic                     wr_en;
    logic                     at_end;
    logic [INC_WIDTH-1:0]     byte_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Zero-latency write path: an accepted beat in WRITE is written in the same cycle.
    always_comb begin
        tready = rdy_q;
`ifdef SN_SEQ_DROP_WHEN_BUSY_EN
        // Never stall the tap while waiting; buf_rdy wins so that packet is written instead.
        if (state == ST_IDLE && !bus.buf_rdy && !rst) begin
            tready = 1'b1;
        end
`endif
        wr_en    = (state == ST_WRITE) && bus.s_tvalid;
        at_end   = (addr == ADDR_LAST);
        byte_inc = '0;
        if (wr_en) begin
            byte_inc = bus.s_tlast ? bus.s_tbytes : FULL_INC;
        end
    end

    assign bus.s_tready    = tready;
    assign bus.in_wr_en    = wr_en;
    assign bus.in_addr     = addr;
    assign bus.in_wr_data  = bus.s_tdata;
    assign bus.in_byte_inc = byte_inc;
    assign bus.in_done     = wr_en && (bus.s_tlast || at_end);
    assign bus.truncated   = wr_en && !bus.s_tlast && at_end;

    // Sequencing FSM with registered ready, address and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr         <= '0;
            rdy_q        <= 1'b0;
            drop_to_idle <= 1'b0;
            pkt_cnt      <= '0;
            trunc_cnt    <= '0;
`ifdef SN_SEQ_DROP_WHEN_BUSY_EN
            drop_cnt     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.buf_rdy) begin
                        state <= ST_WRITE;
                        addr  <= '0;
                        rdy_q <= 1'b1;
                    end
`ifdef SN_SEQ_DROP_WHEN_BUSY_EN
                    else if (bus.s_tvalid) begin
                        // A single-beat packet is fully consumed here, so stay in IDLE.
                        drop_cnt <= sat_inc(drop_cnt);
                        if (!bus.s_tlast) begin
                            state        <= ST_DROP;
                            rdy_q        <= 1'b1;
                            drop_to_idle <= 1'b1;
                        end
                    end
`endif
                end
                ST_WRITE: begin
                    if (bus.s_tvalid) begin
                        if (bus.s_tlast) begin
                            pkt_cnt <= sat_inc(pkt_cnt);
                            state   <= ST_FLUSH;
                            rdy_q   <= 1'b0;
                        end else if (at_end) begin
                            // Buffer full: close the packet now and swallow the remainder.
                            pkt_cnt      <= sat_inc(pkt_cnt);
                            trunc_cnt    <= sat_inc(trunc_cnt);
                            state        <= ST_DROP;
                            drop_to_idle <= 1'b0;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.s_tvalid && bus.s_tlast) begin
                        // Busy drops never owned a buffer, so there is nothing to flush.
                        state <= drop_to_idle ? ST_IDLE : ST_FLUSH;
                        rdy_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                    rdy_q <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef SN_SEQ_DROP_WHEN_BUSY_EN
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_sn_pkt_write_sequencer.sv
// Self-checking bench for sn_pkt_write_sequencer with a 4-word buffer so truncation is
// reachable; writes are compared against a packet-level reference model.
module tb_sn_pkt_write_sequencer;
    localparam int W     = 32;
    localparam int AW    = 2;
    localparam int IW    = 3;
    localparam int CW    = 32;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [IW-1:0] inc;
        logic          done;
        logic          trunc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] pkt_cnt, trunc_cnt, drop_cnt;

    sn_pkt_write_sequencer_if #(.IN_WIDTH(W), .IN_ADDR_WIDTH(AW), .INC_WIDTH(IW)) bus ();

    sn_pkt_write_sequencer #(
        .IN_WIDTH(W), .IN_ADDR_WIDTH(AW), .INC_WIDTH(IW), .CNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pkt_cnt   (pkt_cnt),
        .trunc_cnt (trunc_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int stray_done = 0;
    int m_pkt = 0, m_trunc = 0, m_drop = 0;

    wr_t        wq[$];
    wr_t        eq[$];
    logic [W-1:0] pd[16];
    logic [IW-1:0] pb;

    // Observe every write strobe mid-cycle.
    always @(negedge clk) begin
        if (bus.in_wr_en)
            wq.push_back('{addr: bus.in_addr, data: bus.in_wr_data, inc: bus.in_byte_inc,
                           done: bus.in_done, trunc: bus.truncated});
        if ((bus.in_done || bus.truncated) && !bus.in_wr_en)
            stray_done++;
    end

    task automatic send_beat(input logic [W-1:0] d, input logic last, input logic [IW-1:0] nb,
                             input int gap);
        logic acc;
        int   cyc;
        bus.s_tvalid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.s_tdata  = d;
        bus.s_tlast  = last;
        bus.s_tbytes = nb;
        bus.s_tvalid = 1'b1;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = bus.s_tready;
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL beat_accept_timeout: got no s_tready in %0d cycles, required acceptance", cyc);
        end
    endtask

    // Sends pd[0..n-1] (last beat carries pb bytes); the packet-level model predicts the
    // writes: word i lands at address i, anything past the buffer is discarded, and the
    // packet closes on its last beat or on the final buffer word, whichever comes first.
    task automatic send_packet(input int n, input int gmax, input bit expect_wr,
                               input bit chk_gap, output int gap_low);
        bit seen;
        for (int i = 0; i < n; i++) begin
            if (expect_wr && i < DEPTH)
                eq.push_back('{addr: AW'(i), data: pd[i],
                               inc: (i == n - 1) ? pb : IW'(W / 8),
                               done: (i == n - 1) || (i == DEPTH - 1),
                               trunc: (i == DEPTH - 1) && (n > DEPTH)});
            send_beat(pd[i], i == n - 1, pb, $urandom_range(0, gmax));
        end
        if (expect_wr) begin
            m_pkt++;
            if (n > DEPTH) m_trunc++;
        end
        gap_low = -1;
        if (chk_gap) begin
            gap_low = 0;
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge clk);
                if (bus.s_tready) seen = 1'b1;
                else gap_low++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pd[i] = $urandom();
        pb = IW'($urandom_range(0, W / 8));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.buf_rdy = 1'b0;
        bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.s_tdata = '0; bus.s_tbytes = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.s_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %0b expected 0", bus.s_tready); end
        checks++; if (bus.in_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %0b expected 0", bus.in_wr_en); end
        checks++; if (bus.in_addr !== '0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", bus.in_addr); end
        checks++; if ({bus.in_done, bus.truncated} !== 2'b00) begin failures++; $display("FAIL reset_done: got %b expected 00", {bus.in_done, bus.truncated}); end
        checks++; if ({pkt_cnt, trunc_cnt, drop_cnt} !== '0) begin failures++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", pkt_cnt, trunc_cnt, drop_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_pkt = 0; m_trunc = 0; m_drop = 0;
        wq.delete(); eq.delete();
    endtask

    task automatic test_basic;
        int g;
        bus.buf_rdy = 1'b1;
        pd[0] = 32'hDEADBEEF; pd[1] = 32'h01234567; pd[2] = 32'hCAFE0000; pb = 3'd2;
        send_packet(3, 0, 1'b1, 1'b1, g);
        eq.delete();
        eq.push_back('{addr: 2'd0, data: 32'hDEADBEEF, inc: 3'd4, done: 1'b0, trunc: 1'b0});
        eq.push_back('{addr: 2'd1, data: 32'h01234567, inc: 3'd4, done: 1'b0, trunc: 1'b0});
        eq.push_back('{addr: 2'd2, data: 32'hCAFE0000, inc: 3'd2, done: 1'b1, trunc: 1'b0});
        checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL basic_wr_count: got %0d expected %0d", wq.size(), eq.size()); end
        else foreach (eq[i]) begin
            checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL basic_wr[%0d]: got %h expected %h", i, wq[i], eq[i]); end
        end
        checks++; if (pkt_cnt !== 32'd1) begin failures++; $display("FAIL basic_pkt_cnt: got %0d expected 1", pkt_cnt); end
        checks++; if (g != 2) begin failures++; $display("FAIL basic_flush_gap: got %0d not-ready cycles expected 2", g); end
        wq.delete(); eq.delete();
    endtask

    task automatic test_truncation;
        int g;
        fill_random(6);
        send_packet(6, 1, 1'b1, 1'b1, g);
        checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL trunc_wr_count: got %0d expected %0d", wq.size(), eq.size()); end
        else foreach (eq[i]) begin
            checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL trunc_wr[%0d]: got %h expected %h", i, wq[i], eq[i]); end
        end
        checks++; if (trunc_cnt !== CW'(m_trunc)) begin failures++; $display("FAIL trunc_trunc_cnt: got %0d expected %0d", trunc_cnt, m_trunc); end
        checks++; if (pkt_cnt !== CW'(m_pkt)) begin failures++; $display("FAIL trunc_pkt_cnt: got %0d expected %0d", pkt_cnt, m_pkt); end
        checks++; if (g != 2) begin failures++; $display("FAIL trunc_flush_gap: got %0d expected 2", g); end
        wq.delete(); eq.delete();
    endtask

    task automatic test_exact_fit;
        int g;
        fill_random(4);
        send_packet(4, 1, 1'b1, 1'b1, g);
        checks++; if (wq.size() != 4) begin failures++; $display("FAIL fit_wr_count: got %0d expected 4", wq.size()); end
        else foreach (eq[i]) begin
            checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL fit_wr[%0d]: got %h expected %h", i, wq[i], eq[i]); end
        end
        checks++; if (trunc_cnt !== CW'(m_trunc)) begin failures++; $display("FAIL fit_trunc_cnt: got %0d expected %0d", trunc_cnt, m_trunc); end
        wq.delete(); eq.delete();
    endtask

    task automatic test_reset_mid_packet;
        int g;
        bit any_done;
        send_beat(32'h1111_0000, 1'b0, '0, 0);
        send_beat(32'h2222_0000, 1'b0, '0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pkt = 0; m_trunc = 0; m_drop = 0;
        any_done = 1'b0;
        foreach (wq[i]) any_done |= wq[i].done;
        checks++; if (wq.size() != 2 || any_done) begin failures++; $display("FAIL rstmid_writes: got %0d writes done=%0b expected 2 writes done=0", wq.size(), any_done); end
        checks++; if ({pkt_cnt, trunc_cnt} !== '0) begin failures++; $display("FAIL rstmid_counters: got %0d/%0d expected 0/0", pkt_cnt, trunc_cnt); end
        wq.delete(); eq.delete();
        fill_random(1);
        send_packet(1, 0, 1'b1, 1'b1, g);
        checks++; if (wq.size() != 1 || wq[0] !== eq[0]) begin failures++; $display("FAIL rstmid_next_pkt: got %0d writes first=%h expected %h", wq.size(), (wq.size() > 0) ? wq[0] : '0, eq[0]); end
        checks++; if (pkt_cnt !== 32'd1) begin failures++; $display("FAIL rstmid_pkt_cnt: got %0d expected 1", pkt_cnt); end
        wq.delete(); eq.delete();
    endtask

    task automatic test_busy;
        int g, hi;
        bus.buf_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pkt = 0; m_trunc = 0; m_drop = 0;
        wq.delete(); eq.delete();
`ifdef SN_SEQ_DROP_WHEN_BUSY_EN
        fill_random(3);
        send_packet(3, 1, 1'b0, 1'b0, g);
        m_drop++;
        fill_random(1);
        send_packet(1, 0, 1'b0, 1'b0, g);
        m_drop++;
        @(negedge clk);
        checks++; if (bus.s_tready !== 1'b1) begin failures++; $display("FAIL busy_idle_ready: got %0b expected 1", bus.s_tready); end
        @(posedge clk); #1;
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL busy_drop_writes: got %0d expected 0", wq.size()); end
        checks++; if (drop_cnt !== CW'(m_drop)) begin failures++; $display("FAIL busy_drop_cnt: got %0d expected %0d", drop_cnt, m_drop); end
`else
        hi = 0;
        bus.s_tdata = $urandom(); bus.s_tvalid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.s_tready) hi++;
            @(posedge clk); #1;
        end
        bus.s_tvalid = 1'b0;
        checks++; if (hi != 0) begin failures++; $display("FAIL busy_backpressure: got %0d ready cycles expected 0", hi); end
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL busy_no_writes: got %0d expected 0", wq.size()); end
`endif
        bus.buf_rdy = 1'b1;
        fill_random(3);
        send_packet(3, 1, 1'b1, 1'b1, g);
        checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL busy_after_wr_count: got %0d expected %0d", wq.size(), eq.size()); end
        else foreach (eq[i]) begin
            checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL busy_after_wr[%0d]: got %h expected %h", i, wq[i], eq[i]); end
        end
        wq.delete(); eq.delete();
    endtask

    task automatic test_back_to_back;
        int g, n;
        bus.buf_rdy = 1'b1;
        for (int p = 0; p < 12; p++) begin
            n = $urandom_range(1, 7);
            fill_random(n);
            send_packet(n, 2, 1'b1, 1'b1, g);
            checks++; if (g != 2) begin failures++; $display("FAIL b2b_flush_gap[%0d]: got %0d expected 2", p, g); end
        end
        checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL b2b_wr_count: got %0d expected %0d", wq.size(), eq.size()); end
        else foreach (eq[i]) begin
            checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL b2b_wr[%0d]: got %h expected %h", i, wq[i], eq[i]); end
        end
        checks++; if (pkt_cnt !== CW'(m_pkt) || trunc_cnt !== CW'(m_trunc)) begin failures++; $display("FAIL b2b_counters: got %0d/%0d expected %0d/%0d", pkt_cnt, trunc_cnt, m_pkt, m_trunc); end
        checks++; if (drop_cnt !== CW'(m_drop)) begin failures++; $display("FAIL b2b_drop_cnt: got %0d expected %0d", drop_cnt, m_drop); end
        checks++; if (stray_done != 0) begin failures++; $display("FAIL done_without_wr: got %0d cycles expected 0", stray_done); end
        wq.delete(); eq.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_exact_fit();
        test_reset_mid_packet();
        test_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
